// File: rtl/reg_file_sb.sv
// ============================================================================
// Module   : reg_file_sb
// Brief    : 4-entry, 2W/2R register file with write bypass and a per-register
//            busy scoreboard for RAW/WAW hazard detection at decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb_dec2to4 (
   input  logic       en_i,
   input  logic [1:0] addr_i,
   output logic [3:0] y_o
);
   assign y_o = en_i ? (4'b0001 << addr_i) : 4'b0000;
endmodule

module reg_file_sb #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   rd_addr_a,
   input  logic [1:0]   rd_addr_b,
   input  logic         rd_use_a,
   input  logic         rd_use_b,
   output logic [W-1:0] rd_data_a,
   output logic [W-1:0] rd_data_b,
   output logic         busy_a,
   output logic         busy_b,
   output logic         stall,
   input  logic         iss_en,
   input  logic [1:0]   iss_dst,
   input  logic         wr_en_0,
   input  logic         wr_en_1,
   input  logic [1:0]   wr_addr_0,
   input  logic [1:0]   wr_addr_1,
   input  logic [W-1:0] wr_data_0,
   input  logic [W-1:0] wr_data_1
);

   logic [W-1:0] regs_q [4];
   logic [W-1:0] regs_d [4];
   logic [3:0]   busy_q;
   logic [3:0]   busy_d;
   logic [3:0]   strb0;
   logic [3:0]   strb1;
   logic [3:0]   clr;
   logic [3:0]   iss_set;
   logic         busy_iss;
   logic         iss_ok;

   reg_file_sb_dec2to4 u_dec_wr0 (
      .en_i   (wr_en_0),
      .addr_i (wr_addr_0),
      .y_o    (strb0)
   );

   reg_file_sb_dec2to4 u_dec_wr1 (
      .en_i   (wr_en_1),
      .addr_i (wr_addr_1),
      .y_o    (strb1)
   );

   assign clr = strb0 | strb1;

   // Port 1 has priority in both the bypass and the register update.
   assign rd_data_a = strb1[rd_addr_a] ? wr_data_1 :
                      strb0[rd_addr_a] ? wr_data_0 : regs_q[rd_addr_a];
   assign rd_data_b = strb1[rd_addr_b] ? wr_data_1 :
                      strb0[rd_addr_b] ? wr_data_0 : regs_q[rd_addr_b];

   assign busy_a   = busy_q[rd_addr_a] & ~clr[rd_addr_a];
   assign busy_b   = busy_q[rd_addr_b] & ~clr[rd_addr_b];
   assign busy_iss = busy_q[iss_dst]   & ~clr[iss_dst];

   assign stall   = (rd_use_a & busy_a) | (rd_use_b & busy_b) | (iss_en & busy_iss);
   assign iss_ok  = iss_en & ~stall;
   assign iss_set = iss_ok ? (4'b0001 << iss_dst) : 4'b0000;

   // Set after clear so an accepted issue wins over a same-cycle commit.
   assign busy_d = (busy_q & ~clr) | iss_set;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 4'b0000;
      end else begin
         busy_q <= busy_d;
      end
   end

   generate
      for (genvar i = 0; i < 4; i++) begin : g_reg
         assign regs_d[i] = strb1[i] ? wr_data_1 :
                            strb0[i] ? wr_data_0 : regs_q[i];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               regs_q[i] <= '0;
            end else begin
               regs_q[i] <= regs_d[i];
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Scoreboard bench for reg_file_sb with directed, hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

   localparam int W = 16;

   typedef struct {
      string        name;
      logic [W-1:0] da;
      logic [W-1:0] db;
      logic         ba;
      logic         bb;
      logic         st;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   rd_addr_a, rd_addr_b;
   logic         rd_use_a, rd_use_b;
   logic [W-1:0] rd_data_a, rd_data_b;
   logic         busy_a, busy_b, stall;
   logic         iss_en;
   logic [1:0]   iss_dst;
   logic         wr_en_0, wr_en_1;
   logic [1:0]   wr_addr_0, wr_addr_1;
   logic [W-1:0] wr_data_0, wr_data_1;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_use_a  (rd_use_a),
      .rd_use_b  (rd_use_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .stall     (stall),
      .iss_en    (iss_en),
      .iss_dst   (iss_dst),
      .wr_en_0   (wr_en_0),
      .wr_en_1   (wr_en_1),
      .wr_addr_0 (wr_addr_0),
      .wr_addr_1 (wr_addr_1),
      .wr_data_0 (wr_data_0),
      .wr_data_1 (wr_data_1)
   );

   task automatic cmp(input string name, input string fld, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, fld, act, req);
      end
   endtask

   // Monitor: pops the expectation for the current cycle and compares on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "rd_data_a", rd_data_a, e.da);
            cmp(e.name, "rd_data_b", rd_data_b, e.db);
            cmp(e.name, "busy_a", {{(W-1){1'b0}}, busy_a}, {{(W-1){1'b0}}, e.ba});
            cmp(e.name, "busy_b", {{(W-1){1'b0}}, busy_b}, {{(W-1){1'b0}}, e.bb});
            cmp(e.name, "stall",  {{(W-1){1'b0}}, stall},  {{(W-1){1'b0}}, e.st});
         end
      end
   end

   // Drive one cycle of inputs, post its expected outputs, advance past the edge.
   task automatic step(input string name, input logic rst,
                       input logic [1:0] ra, input logic ua, input logic [1:0] rb, input logic ub,
                       input logic ie, input logic [1:0] idst,
                       input logic we0, input logic [1:0] wa0, input logic [W-1:0] wd0,
                       input logic we1, input logic [1:0] wa1, input logic [W-1:0] wd1,
                       input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic eba, input logic ebb, input logic est);
      exp_t e;
      rst_n     = rst;
      rd_addr_a = ra;  rd_use_a = ua;
      rd_addr_b = rb;  rd_use_b = ub;
      iss_en    = ie;  iss_dst  = idst;
      wr_en_0   = we0; wr_addr_0 = wa0; wr_data_0 = wd0;
      wr_en_1   = we1; wr_addr_1 = wa1; wr_data_1 = wd1;
      e.name = name; e.da = ea; e.db = eb; e.ba = eba; e.bb = ebb; e.st = est;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      rd_addr_a = 2'd0; rd_addr_b = 2'd0; rd_use_a = 1'b0; rd_use_b = 1'b0;
      iss_en = 1'b0; iss_dst = 2'd0;
      wr_en_0 = 1'b0; wr_en_1 = 1'b0; wr_addr_0 = 2'd0; wr_addr_1 = 2'd0;
      wr_data_0 = '0; wr_data_1 = '0;
      @(posedge clk);
      #1;
      //    name          rst ra ua rb ub ie id we0 wa0 wd0      we1 wa1 wd1      exp_a    exp_b    ba bb st
      step("rst1",        0, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h0000,0, 0, 0);
      step("rst2_wrign",  0, 2, 0, 0, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 16'h0000,16'h0000,0, 0, 0);
      step("wr_r2_byp",   1, 2, 0, 3, 0, 0, 0, 1, 2, 16'h1234, 0, 0, 16'h0000, 16'h1234,16'h0000,0, 0, 0);
      step("rd_r2",       1, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h1234,16'h0000,0, 0, 0);
      step("conflict",    1, 1, 0, 2, 0, 0, 0, 1, 1, 16'hAAAA, 1, 1, 16'h5555, 16'h5555,16'h1234,0, 0, 0);
      step("conflict_rd", 1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h5555,16'h5555,0, 0, 0);
      step("iss_r3",      1, 3, 0, 1, 0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h5555,0, 0, 0);
      step("raw_stall1",  1, 3, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h5555,1, 0, 1);
      step("raw_stall2",  1, 3, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h5555,1, 0, 1);
      step("raw_commit",  1, 3, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 3, 16'h00FF, 16'h00FF,16'h5555,0, 0, 0);
      step("raw_after",   1, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h00FF,16'h0000,0, 0, 0);
      step("iss_r0",      1, 0, 0, 3, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h00FF,0, 0, 0);
      step("waw_block",   1, 0, 0, 3, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h00FF,1, 0, 1);
      step("set_over_clr",1, 0, 0, 3, 0, 1, 0, 1, 0, 16'h0C0C, 0, 0, 16'h0000, 16'h0C0C,16'h00FF,0, 0, 0);
      step("r0_still_bsy",1, 0, 0, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0C0C,16'h00FF,1, 0, 0);
      step("r0_commit",   1, 0, 0, 3, 0, 0, 0, 1, 0, 16'h0D0D, 0, 0, 16'h0000, 16'h0D0D,16'h00FF,0, 0, 0);
      step("r0_free",     1, 0, 1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0D0D,16'h00FF,0, 0, 0);
      step("iss_r2",      1, 0, 0, 2, 0, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0D0D,16'h1234,0, 0, 0);
      step("use_b_off",   1, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0D0D,16'h1234,0, 1, 0);
      step("use_b_on",    1, 0, 0, 2, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0D0D,16'h1234,0, 1, 1);
      step("prep_r1",     1, 1, 0, 2, 0, 1, 1, 1, 1, 16'h7777, 1, 2, 16'h2222, 16'h7777,16'h2222,0, 0, 0);
      step("prep_r3",     1, 1, 0, 3, 0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h7777,16'h00FF,1, 0, 0);
      step("mid_rst",     0, 3, 0, 2, 0, 0, 0, 1, 1, 16'h1111, 0, 0, 16'h0000, 16'h00FF,16'h2222,1, 0, 0);
      step("post_rst",    1, 1, 1, 3, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h0000,0, 0, 0);
      step("post_rst_iss",1, 2, 0, 0, 0, 1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,16'h0000,0, 0, 0);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Four-entry, two-write/two-read register file with a per-register busy scoreboard. It sits between the decode and write-back stages of the pipeline. Decode reads operands and registers a pending destination. Write-back commits results and clears the pending marks. Each write port's address is turned into one-hot register strobes by the existing 2-to-4 decoder, instantiated once per write port, with EN = write enable.

## Interface
- W, default 16: data width of every register and data port.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled on rising edge of clk.
- rd_addr_a, rd_addr_b  in  2  read-port register selects.
- rd_use_a, rd_use_b  in  1  decode actually consumes the operand on this port.
- rd_data_a, rd_data_b  out  W  read data, combinational, with write bypass.
- busy_a, busy_b  out  1  the selected register has a pending producer after this cycle's clears.
- stall  out  1  decode must hold; the issue is not accepted this cycle.
- iss_en  in  1  decode issues an instruction that will write iss_dst.
- iss_dst  in  2  destination register of the issuing instruction.
- wr_en_0, wr_en_1  in  1  write-back commit strobes, port 0 and port 1.
- wr_addr_0, wr_addr_1  in  2  commit destinations.
- wr_data_0, wr_data_1  in  W  commit data.

## Operation
- State:
  - regs[0..3], W bits each.
  - busy[0..3], 1 bit each.
  - No other state.
- Reset (rst_n=0 at a rising edge):
  - All regs and busy bits go to 0.
  - Resetting mid-operation discards pending marks and in-flight issues.
  - Writes presented in the reset cycle are ignored.
  - Outputs are combinational from state, so after reset: rd_data_* = 0 unless bypassed; busy_* = 0; stall = 0 unless busy bits are set in the same cycle.
- Write:
  - Port p writes regs[wr_addr_p] <= wr_data_p when wr_en_p=1.
  - If both ports target the same register in the same cycle, port 1 wins.
- Read bypass, evaluated per read port in priority order:
  - if wr_en_1 and wr_addr_1 == rd_addr: wr_data_1;
  - else if wr_en_0 and wr_addr_0 == rd_addr: wr_data_0;
  - else regs[rd_addr].
- Busy clear: any wr_en_p with wr_addr_p = r clears busy[r] at the edge.
- busy_a / busy_b:
  - busy_x = busy[rd_addr_x] AND NOT (a write this cycle targets rd_addr_x).
  - This is consistent with the data bypass.
- stall = (rd_use_a AND busy_a) OR (rd_use_b AND busy_b) OR (iss_en AND busy_iss).
  - busy_iss is busy[iss_dst] with the same same-cycle clear applied.
  - The last term blocks write-after-write to a pending register.
- Issue acceptance:
  - Accepted when iss_en=1 and stall=0; then busy[iss_dst] <= 1.
  - If an accepted issue and a commit hit the same register in the same cycle, set wins and busy stays 1.
- Writes are never blocked by stall. Write-back always commits.
- Writes to a non-busy register are legal: the data is written and busy stays 0.

## Timing
- Read path is combinational: zero-cycle latency from regs or bypass to rd_data.
- Write latency: a commit at edge N is visible from regs in cycle N+1. It is visible via bypass in cycle N itself.
- Scoreboard:
  - An issue accepted at edge N makes busy visible in cycle N+1.
  - A commit at edge N drops busy_x in cycle N itself via the clear term.
- stall and busy_* are purely combinational. There is no registered hazard path, so a stalled decode re-evaluates every cycle.
- Combinational loops:
  - The stall→issue gating is internal; stall is not a function of state updated in the same cycle.
  - There is no dependency from stall back to rd_*, wr_*, or iss_* inputs.

## Test plan
- Reset and basic write/read:
  - Stimulus: rst_n=0 for 2 cycles; then write R2=0x1234 via port 0; read a=2, b=0 the next cycle.
  - Required: during reset all rd_data are 0; afterwards rd_data_a=0x1234, rd_data_b=0x0000, busy_* = 0.
- Bypass and port conflict:
  - Stimulus: same cycle, port 0 writes R1=0xAAAA and port 1 writes R1=0x5555; read a=1.
  - Required: rd_data_a=0x5555 in that cycle and after; next-cycle read gives 0x5555.
- RAW stall:
  - Stimulus: issue dst=R3; next cycle rd_addr_a=3, rd_use_a=1.
  - Required: busy_a=1, stall=1 each cycle until the port 1 commit R3=0x00FF. In the commit cycle: busy_a=0, stall=0, rd_data_a=0x00FF.
- WAW block and set-over-clear:
  - Stimulus: issue R0; next cycle issue R0 again with no commit.
  - Required: stall=1 and the second issue is not accepted.
  - Stimulus: then commit R0 together with an issue of R0 in the same cycle.
  - Required: stall=0, issue accepted, busy[0] stays 1 in the next cycle.
- rd_use gating:
  - Stimulus: R2 busy, rd_addr_b=2, rd_use_b=0.
  - Required: busy_b=1, stall=0.
- Reset mid-operation:
  - Stimulus: R1 and R3 busy, R1=0x7777; assert rst_n=0 for 1 cycle alongside a commit R1=0x1111.
  - Required: next cycle R1 reads 0x0000, all busy = 0, stall=0.
